adc0809_responder: RTL and testbench
====================================

Name: adc0809_responder

Overview:
- Synthesizable responder-side emulation of the ADC0809 8-channel SAR converter.
- Sits on the far end of the ADC control bus driven by the acquisition front end: ale, start, oe, address, adc_clock in; eoc and adc_data out.
- Lets the full acquisition/BCD/LCD chain be exercised on the board or in simulation without a physical ADC.
- Eight channel values come from a packed input bus: switches, a pattern generator or a testbench.

Parameters:
- CONV_CYCLES, 64: adc_clock rising edges from EOC low to EOC high (conversion time).
- EOC_DELAY, 8: adc_clock rising edges after START falls before EOC drops.
- DATA_W, 8: conversion result width.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- adc_clock  in  1  converter clock from the initiator; asynchronous to clock, sampled only.
- ale  in  1  address latch enable.
- start  in  1  conversion start pulse.
- oe  in  1  output enable.
- address  in  3  channel select.
- ch_data  in  8*DATA_W  packed channel values; channel n = ch_data[n*DATA_W +: DATA_W].
- eoc  out  1  end of conversion; high = idle/done.
- adc_data  out  DATA_W  result while oe=1, else 0.
- data_oe  out  1  registered copy of oe, for external tri-state.
- busy  out  1  high from START rise until EOC returns high.

Behaviour:
- Reset, synchronous: state IDLE, eoc=1, adc_data=0, data_oe=0, busy=0, latched address=0, result=0, counters=0. Reset overrides any operation in progress, including mid-conversion.
- adc_clock handling:
  - Passes through a 2-flop synchronizer, then a third flop.
  - tick = sync2 & ~sync3.
  - All delays count ticks, not clock cycles.
- Address latch: while ale=1, the latched address follows address each clock. It holds when ale=0.
- start edges: registered and edge-detected in the clock domain.
- States:
  - IDLE: eoc=1, busy=0. On START rise go to HOLD.
  - HOLD: busy=1, eoc unchanged. On START fall:
    - snapshot sample = channel[latched address];
    - clear the counter;
    - go to WAIT.
  - WAIT: eoc=1. Count ticks. On the EOC_DELAY-th tick: eoc=0, counter cleared, go to CONV.
  - CONV: eoc=0. Count ticks. On the CONV_CYCLES-th tick: result = sample, eoc=1, busy=0, go to DONE.
  - DONE: result held. START rise goes to HOLD. Otherwise stay.
- Abort: a START rise in WAIT or CONV goes to HOLD. eoc returns to 1 the next clock. The old result is retained, not updated.
- Simultaneous events:
  - START rise and the final tick in the same clock: the abort wins and result is not updated.
  - ale=1 during CONV: address re-latches, but the sample already taken is unaffected.
- Output path:
  - adc_data <= oe ? result : 0; data_oe <= oe. One clock latency, independent of state.
  - oe during CONV returns the previous result.
- Counters: width clog2(max(CONV_CYCLES, EOC_DELAY)+1). They never wrap; they are cleared on every state entry.
- Timing: the first conversion after reset takes EOC_DELAY+CONV_CYCLES ticks from START fall to eoc=1, plus 2–3 clocks of synchronizer latency.

Optional Feature:
- Macro: ADC_NOISE_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 0xA5 on reset) advances once per completed conversion.
  - When lfsr[1]=1, result = sample + 1 if lfsr[0]=1, else sample - 1.
  - Result saturates at 0 and 2^DATA_W-1.
- Undefined: result = sample exactly; no LFSR logic present.

Decomposition:
- Package adc0809_pkg:
  - state enum {IDLE, HOLD, WAIT, CONV, DONE};
  - ADC_CH_NUM=8;
  - ADC_ADDR_W=3;
  - LFSR_SEED=8'hA5.
- Sub-module adc_clk_edge: 2-flop synchronizer plus rising-edge detect producing tick. It is reused by any block sampling adc_clock.

Test Plan:
- Reset check: reset held for 3 clocks -> eoc=1, adc_data=0, busy=0, data_oe=0. Reset high for 1 clock mid-CONV -> next clock state IDLE, eoc=1.
- Single conversion:
  - Stimulus: ch3=0x9C; ale pulse with address=3; START pulse; adc_clock = clock/8; defaults.
  - Response: eoc falls 8 ticks after START fall and rises 64 ticks later. busy is high over exactly that span plus HOLD.
  - With oe=1: adc_data=0x9C one clock after oe rises; adc_data=0 one clock after oe falls.
- Channel sweep: ch0..7 = 0x00,0x24,0x49,0x6D,0x92,0xB6,0xDB,0xFF; convert each address -> read values match exactly, including boundaries 0x00 and 0xFF.
- Abort: START re-pulsed at tick 30 of CONV -> eoc=1 next clock, prior result kept. The next conversion completes normally with the new sample.
- Sample timing: ch5 changes 0x10→0x20 during CONV, ale re-pulsed with address=2 -> result = 0x10.
- With ADC_NOISE_EN: ch0=0xFF and ch1=0x00 converted 16 times each -> results always within ±1 and never wrap (0xFF never becomes 0x00, 0x00 never becomes 0xFF). Sequence is identical across two runs after reset.

Source files
------------

// File: rtl/adc0809_pkg.sv
// Shared types and constants for the ADC0809 responder emulation.
package adc0809_pkg;

  localparam int unsigned ADC_CH_NUM = 8;
  localparam int unsigned ADC_ADDR_W = 3;
  localparam logic [7:0]  LFSR_SEED  = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StWait,
    StConv,
    StDone
  } adc_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

endpackage

// File: rtl/adc_clk_edge.sv
// Synchronizes an external adc_clock into the system domain and emits a
// one-clock tick per rising edge.
module adc_clk_edge (
  input  logic clock_i,
  input  logic reset_i,
  input  logic adc_clock_i,
  output logic tick_o
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= adc_clock_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tick_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/adc0809_responder.sv
// Responder-side ADC0809 emulation: latches address, times a conversion in
// adc_clock ticks and returns the selected channel value. Optional noise: ADC_NOISE_EN.
module adc0809_responder
  import adc0809_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 64,
  parameter int unsigned EOC_DELAY   = 8,
  parameter int unsigned DATA_W      = 8
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         adc_clock_i,
  input  logic                         ale_i,
  input  logic                         start_i,
  input  logic                         oe_i,
  input  logic [ADC_ADDR_W-1:0]        address_i,
  input  logic [ADC_CH_NUM*DATA_W-1:0] ch_data_i,
  output logic                         eoc_o,
  output logic [DATA_W-1:0]            adc_data_o,
  output logic                         data_oe_o,
  output logic                         busy_o
);

  localparam int unsigned CntMax = max_u(CONV_CYCLES, EOC_DELAY);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic tick;

  adc_clk_edge u_adc_clk_edge (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .adc_clock_i (adc_clock_i),
    .tick_o      (tick)
  );

  logic [DATA_W-1:0] ch_arr [ADC_CH_NUM];
  for (genvar g = 0; g < ADC_CH_NUM; g++) begin : g_ch
    assign ch_arr[g] = ch_data_i[g*DATA_W +: DATA_W];
  end

  adc_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] conv_result;
  logic [ADC_ADDR_W-1:0] addr_q;
  logic start_q, start_prev_q;
  logic start_rise, start_fall;
  logic conv_done;
  logic eoc_q, busy_q, data_oe_q;
  logic [DATA_W-1:0] adc_data_q;

  assign start_rise = start_q & ~start_prev_q;
  assign start_fall = ~start_q & start_prev_q;

`ifdef ADC_NOISE_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d      = conv_done ? lfsr_next(lfsr_q) : lfsr_q;
    conv_result = sample_q;
    // Saturate instead of wrapping at the rails.
    if (lfsr_q[1]) begin
      if (lfsr_q[0]) begin
        conv_result = (sample_q == '1) ? sample_q : sample_q + DATA_W'(1);
      end else begin
        conv_result = (sample_q == '0) ? sample_q : sample_q - DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign conv_result = sample_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    result_d  = result_q;
    conv_done = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_rise) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (start_fall) begin
          sample_d = ch_arr[addr_q];
          cnt_d    = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (start_rise) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CntW'(EOC_DELAY - 1)) begin
            state_d = StConv;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StConv: begin
        // An abort on the final tick wins; the result is left untouched.
        if (start_rise) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CntW'(CONV_CYCLES - 1)) begin
            state_d   = StDone;
            cnt_d     = '0;
            result_d  = conv_result;
            conv_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sample_q     <= '0;
      result_q     <= '0;
      addr_q       <= '0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      eoc_q        <= 1'b1;
      busy_q       <= 1'b0;
      adc_data_q   <= '0;
      data_oe_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      result_q     <= result_d;
      if (ale_i) addr_q <= address_i;
      start_q      <= start_i;
      start_prev_q <= start_q;
      eoc_q        <= (state_d != StConv);
      busy_q       <= (state_d == StHold) || (state_d == StWait) || (state_d == StConv);
      adc_data_q   <= oe_i ? result_q : '0;
      data_oe_q    <= oe_i;
    end
  end

  assign eoc_o      = eoc_q;
  assign busy_o     = busy_q;
  assign adc_data_o = adc_data_q;
  assign data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_adc0809_responder.sv
// Directed + randomized bench for adc0809_responder with a transaction-level
// model of channel snapshots, tick timing and result retention.
module tb_adc0809_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        adc_clock = 1'b0;
  logic        ale = 1'b0;
  logic        start = 1'b0;
  logic        oe = 1'b0;
  logic [2:0]  address = '0;
  logic [63:0] ch_data = '0;
  logic        eoc;
  logic [7:0]  adc_data;
  logic        data_oe;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int adc_edges = 0;

  logic [7:0] mdl_ch [8];
  logic [7:0] pending;
  logic [7:0] exp_result;
  logic [2:0] cur_addr;
  int edges_fall, edges_low;

  adc0809_responder dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .adc_clock_i (adc_clock),
    .ale_i       (ale),
    .start_i     (start),
    .oe_i        (oe),
    .address_i   (address),
    .ch_data_i   (ch_data),
    .eoc_o       (eoc),
    .adc_data_o  (adc_data),
    .data_oe_o   (data_oe),
    .busy_o      (busy)
  );

  always #5 clock = ~clock;

  // adc_clock = clock/8, phase-offset so its edges never coincide with clock edges.
  initial begin
    #2;
    forever #40 adc_clock = ~adc_clock;
  end

  always @(posedge adc_clock) adc_edges <= adc_edges + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int idx, input logic [7:0] val);
    mdl_ch[idx] = val;
    ch_data[idx*8 +: 8] = val;
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    exp_result = 8'h00;
  endtask

  task automatic latch_addr(input logic [2:0] a);
    @(negedge clock);
    ale = 1'b1;
    address = a;
    @(negedge clock);
    ale = 1'b0;
    cur_addr = a;
  endtask

  task automatic wait_eoc(input logic level, input int budget);
    int n = 0;
    while (eoc !== level && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("eoc_wait_%0b", level), eoc, level);
  endtask

  task automatic read_out(output logic [7:0] v);
    @(negedge clock);
    oe = 1'b1;
    @(negedge clock);
    v = adc_data;
    chk("data_oe_hi", data_oe, 1'b1);
    oe = 1'b0;
    @(negedge clock);
    chk("adc_data_off", adc_data, 8'h00);
    chk("data_oe_lo", data_oe, 1'b0);
  endtask

  task automatic conv_start(input logic [2:0] a);
    latch_addr(a);
    @(negedge clock);
    start = 1'b1;
    repeat (3) @(negedge clock);
    chk("hold_busy", busy, 1'b1);
    chk("hold_eoc", eoc, 1'b1);
  endtask

  // Drop START a few clocks after an adc_clock edge so the tick count is unambiguous.
  task automatic conv_release();
    @(posedge adc_clock);
    repeat (4) @(negedge clock);
    start = 1'b0;
    pending = mdl_ch[cur_addr];
    edges_fall = adc_edges;
    wait_eoc(1'b0, 200);
    edges_low = adc_edges;
    chk("eoc_delay_ticks", edges_low - edges_fall, 8);
    chk("conv_busy", busy, 1'b1);
  endtask

  task automatic conv_finish(input string tag, output logic [7:0] v);
    wait_eoc(1'b1, 1000);
    chk("conv_ticks", adc_edges - edges_low, 64);
    chk("done_busy", busy, 1'b0);
    read_out(v);
`ifdef ADC_NOISE_EN
    chk({tag, "_noise"}, (int'(v) - int'(pending) <= 1) && (int'(pending) - int'(v) <= 1), 1);
    exp_result = v;
`else
    chk(tag, v, pending);
    exp_result = pending;
`endif
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] sweep [8];
    logic [7:0] run_a [32];
    logic [2:0] ra;
    int n;

    sweep = '{8'h00, 8'h24, 8'h49, 8'h6D, 8'h92, 8'hB6, 8'hDB, 8'hFF};
    for (int i = 0; i < 8; i++) set_ch(i, 8'($urandom));
    cur_addr = 3'd0;

    // Reset state
    do_reset(3);
    chk("rst_eoc", eoc, 1'b1);
    chk("rst_adc_data", adc_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data_oe", data_oe, 1'b0);
    read_out(v);
    chk("rst_result", v, 8'h00);

    // Single conversion on channel 3
    set_ch(3, 8'h9C);
    conv_start(3'd3);
    conv_release();
    conv_finish("single_ch3", v);

    // Channel sweep including rails
    for (int i = 0; i < 8; i++) begin
      set_ch(i, sweep[i]);
      conv_start(3'(i));
      conv_release();
      conv_finish($sformatf("sweep_ch%0d", i), v);
    end

    // Random channels and addresses
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) set_ch(i, 8'($urandom));
      ra = 3'($urandom_range(0, 7));
      conv_start(ra);
      conv_release();
      conv_finish("rand_conv", v);
    end

    // Abort at tick 30 of CONV keeps the prior result
    set_ch(4, 8'h3C);
    conv_start(3'd4);
    conv_release();
    n = 0;
    while (adc_edges < edges_low + 30 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("abort_reached_tick30", adc_edges >= edges_low + 30, 1);
    start = 1'b1;
    repeat (2) @(negedge clock);
    chk("abort_eoc", eoc, 1'b1);
    chk("abort_busy", busy, 1'b1);
    read_out(v);
    chk("abort_keeps_result", v, exp_result);
    set_ch(4, 8'hC3);
    conv_release();
    conv_finish("after_abort", v);

    // Channel change and address re-latch during CONV leave the sample alone
    set_ch(5, 8'h10);
    conv_start(3'd5);
    conv_release();
    repeat (20) @(negedge clock);
    set_ch(5, 8'h20);
    latch_addr(3'd2);
    conv_finish("sample_timing", v);

    // Reset mid-CONV
    conv_start(3'd1);
    conv_release();
    repeat (20) @(negedge clock);
    do_reset(1);
    chk("midrst_eoc", eoc, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    read_out(v);
    chk("midrst_result", v, 8'h00);
    set_ch(6, 8'h5A);
    conv_start(3'd6);
    conv_release();
    conv_finish("post_reset", v);

`ifdef ADC_NOISE_EN
    // Rails never wrap; sequence repeats identically after reset
    set_ch(0, 8'hFF);
    set_ch(1, 8'h00);
    for (int r = 0; r < 2; r++) begin
      do_reset(3);
      for (int i = 0; i < 32; i++) begin
        conv_start(3'(i % 2));
        conv_release();
        conv_finish("noise_rail", v);
        if (r == 0) run_a[i] = v;
        else        chk("noise_repeat", v, run_a[i]);
        if (i % 2 == 0) chk("noise_no_wrap_ff", v >= 8'hFE, 1);
        else            chk("noise_no_wrap_00", v <= 8'h01, 1);
      end
    end
`else
    run_a[0] = 8'h00;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
